// File: rtl/multiword_add_ctrl.sv
// Multiword add/subtract controller: one 32-bit ripple slice
// is reused across NWORDS words, least significant word first.
module multiword_add_ctrl #(
  parameter  int NWORDS = 4,
  localparam int W      = 32 * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_c,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NWORDS-1:0][31:0] a_q, b_q, sum_q;
  logic [IW-1:0]           idx_q;
  logic                    carry_q;
  logic                    c_out_q;

  logic        accept, step, last;
  logic [31:0] a_w, b_w, slice_sum;
  logic [32:0] chain;

  // Single 32-bit ripple-carry slice, shared by all words
  always_comb begin
    a_w       = a_q[idx_q];
    b_w       = b_q[idx_q];
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < 32; i++) begin
      slice_sum[i] = a_w[i] ^ b_w[i] ^ chain[i];
      chain[i+1]   = (a_w[i] & b_w[i])
                   | (chain[i] & (a_w[i] ^ b_w[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? 1'b1 : in_c;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q] <= slice_sum;
      carry_q      <= chain[32];
      if (last) begin
        c_out_q <= chain[32];
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench for multiword_add_ctrl with NWORDS=4.
// Driver pushes expectations; a negedge monitor pops and checks.
module tb_multiword_add_ctrl;

  localparam int N = 4;
  localparam int W = 32 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  multiword_add_ctrl #(.NWORDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b,
                       logic c, logic sub,
                       logic [W-1:0] es, logic ec,
                       bit push);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_sub   = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    if (push) begin
      e.s   = es;
      e.c   = ec;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: checks every DONE cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", out_valid, 0);
        end else begin
          e = sb[0];
          if (!prev_ov) chk("latency", cyc - e.acc, N);
          chk("sum", sum, e.s);
          chk("c_out", c_out, e.c);
          chk("in_ready_done", in_ready, 0);
          chk("busy_done", busy, 1);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);

    do_op(128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0,
          128'h1_0000_0000, 1'b0, 1'b1);
    do_op(ONES, 128'h0, 1'b1, 1'b0, 128'h0, 1'b1, 1'b1);
    do_op(128'h7, 128'h5, 1'b0, 1'b1, 128'h2, 1'b1, 1'b1);
    do_op(128'h5, 128'h7, 1'b0, 1'b1,
          {{(W-4){1'b1}}, 4'hE}, 1'b0, 1'b1);
    do_op(128'h7, 128'h5, 1'b1, 1'b1, 128'h2, 1'b1, 1'b1);
    do_op(128'h1, 128'h2, 1'b1, 1'b0, 128'h4, 1'b0, 1'b1);
    do_op(MSB, MSB, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1);
    drain();

    // Back-pressure: hold in DONE while inputs churn
    out_ready = 1'b0;
    do_op(128'h0000_0001_0000_0002_0000_0003_0000_0004,
          128'h0000_0005_0000_0006_0000_0007_0000_0008,
          1'b0, 1'b0,
          128'h0000_0006_0000_0008_0000_000A_0000_000C,
          1'b0, 1'b1);
    for (int i = 0; i < N; i++) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_c     = ~in_c;
      in_sub   = ~in_sub;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("handoff_valid", out_valid, 0);
    chk("handoff_ready", in_ready, 1);
    chk("handoff_busy", busy, 0);
    chk("handoff_sb", sb.size(), 0);

    // Reset sampled at the edge ending the third RUN cycle
    do_op(128'h3, 128'h4, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_c_out", c_out, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_valid", out_valid, 0);
    end
    do_op(128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
          128'h1_0000_0000_0000_0000, 1'b0, 1'b1);
    drain();
    tick();
    chk("end_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
